// File: rtl/shift_issue_unit_pkg.sv
// Shared types and constants for the shift issue unit and its shift core.
// SHIFT_ROTATE_EN adds a per-request rotate flag to the queued request.
package shift_issue_unit_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef struct packed {
        logic              dir;
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] data;
`ifdef SHIFT_ROTATE_EN
        logic              rot;
`endif
    } req_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/shift_issue_unit_if.sv
// Request/result handshake bundle of the shift issue unit; master drives requests.
// in_rot exists only when SHIFT_ROTATE_EN is defined.
interface shift_issue_unit_if
    import shift_issue_unit_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_dir;
    logic [AMT_W-1:0]         in_amt;
    logic [DATA_W-1:0]        in_data;
`ifdef SHIFT_ROTATE_EN
    logic                     in_rot;
`endif
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_dir;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_dir, in_amt, in_data,
`ifdef SHIFT_ROTATE_EN
        output in_rot,
`endif
        output out_ready,
        input  in_ready, out_valid, out_data, out_dir, count
    );

    modport slave (
        input  in_valid, in_dir, in_amt, in_data,
`ifdef SHIFT_ROTATE_EN
        input  in_rot,
`endif
        input  out_ready,
        output in_ready, out_valid, out_data, out_dir, count
    );

endinterface

// File: rtl/shift_issue_unit_shift_core.sv
// Combinational 32-bit logical shifter; with SHIFT_ROTATE_EN also rotates.
// Zero latency, no handshake.
module shift_core
    import shift_issue_unit_pkg::*;
(
    input  logic              dir,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] data,
`ifdef SHIFT_ROTATE_EN
    input  logic              rot,
`endif
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shl;
    logic [DATA_W-1:0] shr;

    assign shl = data << amt;
    assign shr = data >> amt;

`ifdef SHIFT_ROTATE_EN
    // (32 - amt) mod 32: for amt = 0 the wrapped part equals data, so OR-ing is harmless
    logic [AMT_W-1:0] inv_amt;
    assign inv_amt = AMT_W'(0) - amt;

    always_comb begin
        result = (dir == LEFT) ? shl : shr;
        if (rot) begin
            result = (dir == LEFT) ? (shl | (data >> inv_amt))
                                   : (shr | (data << inv_amt));
        end
    end
`else
    assign result = (dir == LEFT) ? shl : shr;
`endif

endmodule

// File: rtl/shift_issue_unit.sv
// Queues shift requests in a DEPTH-entry FIFO and issues one per cycle into a registered result stage; 2-cycle latency.
// Backpressure: out_ready low stalls the result stage, FIFO fills, in_ready (registered) drops at full. SHIFT_ROTATE_EN adds rotate.
module shift_issue_unit
#(
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    shift_issue_unit_if.slave bus
);
    import shift_issue_unit_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic              in_ready_q;
    logic              push;
    logic              pop;
    req_t              req_in;
    req_t              head;
    logic [DATA_W-1:0] shift_res;

    out_state_t        state_q;
    out_state_t        state_nxt;
    logic [DATA_W-1:0] out_data_q;
    logic              out_dir_q;

    assign push      = bus.in_valid && in_ready_q;
    assign pop       = (count_q != '0) && ((state_q == OUT_EMPTY) || bus.out_ready);
    assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        req_in      = '0;
        req_in.dir  = bus.in_dir;
        req_in.amt  = bus.in_amt;
        req_in.data = bus.in_data;
`ifdef SHIFT_ROTATE_EN
        req_in.rot  = bus.in_rot;
`endif
    end

    // Storage is not reset: only pointers and occupancy define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q    <= count_nxt;
            in_ready_q <= (count_nxt < CNT_W'(DEPTH));
        end
    end

    assign head = mem[rd_ptr];

    shift_core u_shift_core (
        .dir    (head.dir),
        .amt    (head.amt),
        .data   (head.data),
`ifdef SHIFT_ROTATE_EN
        .rot    (head.rot),
`endif
        .result (shift_res)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            OUT_EMPTY: if (pop) state_nxt = OUT_FULL;
            OUT_FULL:  if (bus.out_ready && !pop) state_nxt = OUT_EMPTY;
            default:   state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OUT_EMPTY;
            out_data_q <= '0;
            out_dir_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (pop) begin
                out_data_q <= shift_res;
                out_dir_q  <= head.dir;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == OUT_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_dir   = out_dir_q;
    assign bus.count     = count_q;

endmodule
